pll_lock_detect: RTL and testbench
==================================

// Module: pll_lock_detect
// PURPOSE
//   Digital frequency lock detector sitting directly downstream of the PLL
//   output divider. Runs on the 100 MHz reference clock. Counts toggles of the
//   divided PLL feedback signal over a fixed reference window and compares the
//   count to an expected value. Asserts lock after consecutive in-tolerance
//   windows and drops lock after consecutive out-of-tolerance windows.
// PARAMETERS
//   WIN_CYC     1024  reference cycles per measurement window (>=8)
//   CNT_W       16    width of the toggle counter and count outputs
//   EXP_CNT     320   expected toggles/window (1 GHz clkout, /32 divider, 10.24 us)
//   TOL         1     allowed |count-EXP_CNT| for a window to count as good
//   LOCK_WINS   4     consecutive good windows required to assert lock
//   UNLOCK_WINS 2     consecutive bad windows required to drop lock
// PORTS
//   clk         in   1      reference clock (clkin, 100 MHz)
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      detector enable; low aborts and clears state
//   fb_tog      in   1      async divided-feedback toggle; rate < clk/2 guaranteed upstream
//   cnt_valid   out  1      one-cycle pulse, window result on cnt_last/cnt_err
//   cnt_last    out  CNT_W  toggle count of the last completed window
//   cnt_err     out  CNT_W+1 signed cnt_last - EXP_CNT
//   lock        out  1      frequency lock indicator
//   lost_lock   out  1      sticky: set on LOCKED->ACQUIRE, cleared only by en low or reset
// BEHAVIOUR
//   Reset: all outputs 0, counters 0, state IDLE, sync flops 0.
//   fb_tog passes a 2-flop synchronizer (always running), then a 3rd flop;
//     a toggle is any change between flop 2 and flop 3 (both edges count).
//   States: IDLE, ACQUIRE, LOCKED.
//     IDLE: en=1 -> ACQUIRE next cycle; window/toggle/good/bad counters zeroed.
//     ACQUIRE: lock=0. After LOCK_WINS consecutive good windows -> LOCKED.
//       A bad window clears the good counter.
//     LOCKED: lock=1. After UNLOCK_WINS consecutive bad windows -> ACQUIRE,
//       lost_lock<=1. A good window clears the bad counter.
//     Any state: en=0 -> IDLE next cycle, lock=0, lost_lock=0, window aborted,
//       no cnt_valid for the partial window.
//   Window: cycle counter runs 0..WIN_CYC-1 in ACQUIRE/LOCKED; on cycle
//     WIN_CYC-1 the count (including a toggle detected that same cycle) is
//     latched to cnt_last, cnt_err updated, cnt_valid pulses the NEXT cycle,
//     and the toggle counter restarts at 0 (or 1 if a toggle occurs on cycle 0).
//   Good window: EXP_CNT-TOL <= count <= EXP_CNT+TOL (inclusive, unsigned compare
//     with EXP_CNT-TOL clamped at 0).
//   Toggle counter saturates at 2^CNT_W-1 (never wraps); saturated window is bad.
//   lock/state changes take effect the same cycle cnt_valid is high.
//   cnt_last/cnt_err hold their value until the next completed window.
//   Latency: first cnt_valid WIN_CYC+1 cycles after en sampled high.
// TESTING
//   1 Reset: assert rst_n=0 mid-run -> all outputs 0 immediately, IDLE after release.
//   2 Lock: en=1, fb_tog toggling every 32 ref cycles/10 (320 per window) ->
//     cnt_last=320, cnt_err=0, lock rises with the 4th cnt_valid.
//   3 Tolerance edges: 319 and 321 toggles/window -> good (locks); 318 or 322
//     -> bad, lock never asserts, cnt_err=-2/+2.
//   4 Loss: locked, then 2 windows at 300 toggles -> lock falls with 2nd
//     cnt_valid, lost_lock=1; a single bad window between good ones keeps lock.
//   5 Saturation: CNT_W=8, 300 toggles/window -> cnt_last=255, window bad, no wrap.
//   6 Abort: en low at cycle 500 of a window -> no cnt_valid, lock=0,
//     lost_lock=0 next cycle; re-enable -> fresh full-length window.

Source files
------------

// File: rtl/pll_lock_detect.sv
// Windowed frequency lock detector for the divided PLL feedback: counts synchronized
// fb_tog edges per reference window and tracks lock with enter/exit hysteresis.
module pll_lock_detect #(
   parameter int unsigned WIN_CYC     = 1024,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned EXP_CNT     = 320,
   parameter int unsigned TOL         = 1,
   parameter int unsigned LOCK_WINS   = 4,
   parameter int unsigned UNLOCK_WINS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    fb_tog,
   output logic                    cnt_valid,
   output logic [CNT_W-1:0]        cnt_last,
   output logic signed [CNT_W:0]   cnt_err,
   output logic                    lock,
   output logic                    lost_lock
);

   localparam int unsigned WIN_W   = $clog2(WIN_CYC);
   localparam int unsigned GW_W    = $clog2(LOCK_WINS + 1);
   localparam int unsigned BW_W    = $clog2(UNLOCK_WINS + 1);
   localparam int unsigned GOOD_LO = (EXP_CNT > TOL) ? EXP_CNT - TOL : 0;
   localparam int unsigned GOOD_HI = EXP_CNT + TOL;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]   EXP_EXT   = (CNT_W+1)'(EXP_CNT);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYC - 1);
   localparam logic [GW_W-1:0]  GOOD_LAST = GW_W'(LOCK_WINS - 1);
   localparam logic [BW_W-1:0]  BAD_LAST  = BW_W'(UNLOCK_WINS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQUIRE,
      ST_LOCKED
   } state_t;

   logic [2:0]       sync_q, sync_d;
   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
   logic [CNT_W-1:0] cnt_last_q, cnt_last_d;
   logic [CNT_W:0]   cnt_err_q, cnt_err_d;
   logic [GW_W-1:0]  good_q, good_d;
   logic [BW_W-1:0]  bad_q, bad_d;
   logic             cnt_valid_q, cnt_valid_d;
   logic             lock_q, lock_d;
   logic             lost_lock_q, lost_lock_d;

   logic             tog;
   logic [CNT_W-1:0] tog_sum;
   logic             win_end;
   logic             win_good;

   // Window datapath: tog_sum already includes a toggle seen on the current cycle,
   // so the last-cycle capture does not miss a toggle landing on the boundary.
   always_comb begin
      sync_d   = {sync_q[1:0], fb_tog};
      tog      = sync_q[1] ^ sync_q[2];
      tog_sum  = (tog && (tog_cnt_q != CNT_MAX)) ? tog_cnt_q + CNT_W'(1) : tog_cnt_q;
      win_end  = (win_cnt_q == WIN_LAST);
      win_good = (tog_sum != CNT_MAX) &&
                 (32'(tog_sum) >= GOOD_LO) && (32'(tog_sum) <= GOOD_HI);
   end

   always_comb begin
      state_d     = state_q;
      win_cnt_d   = win_cnt_q;
      tog_cnt_d   = tog_cnt_q;
      cnt_last_d  = cnt_last_q;
      cnt_err_d   = cnt_err_q;
      good_d      = good_q;
      bad_d       = bad_q;
      cnt_valid_d = 1'b0;
      lock_d      = lock_q;
      lost_lock_d = lost_lock_q;

      if (!en) begin
         // Abort: the partial window is dropped, results of the last full window stay.
         state_d     = ST_IDLE;
         win_cnt_d   = '0;
         tog_cnt_d   = '0;
         good_d      = '0;
         bad_d       = '0;
         lock_d      = 1'b0;
         lost_lock_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = ST_ACQUIRE;
               win_cnt_d = '0;
               tog_cnt_d = '0;
               good_d    = '0;
               bad_d     = '0;
               lock_d    = 1'b0;
            end

            ST_ACQUIRE, ST_LOCKED: begin
               if (!win_end) begin
                  win_cnt_d = win_cnt_q + WIN_W'(1);
                  tog_cnt_d = tog_sum;
               end else begin
                  win_cnt_d   = '0;
                  tog_cnt_d   = '0;
                  cnt_last_d  = tog_sum;
                  cnt_err_d   = (CNT_W+1)'(tog_sum) - EXP_EXT;
                  cnt_valid_d = 1'b1;

                  if (state_q == ST_ACQUIRE) begin
                     if (!win_good) begin
                        good_d = '0;
                     end else if (good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                        good_d  = '0;
                        bad_d   = '0;
                     end else begin
                        good_d = good_q + GW_W'(1);
                     end
                  end else begin
                     if (win_good) begin
                        bad_d = '0;
                     end else if (bad_q == BAD_LAST) begin
                        state_d     = ST_ACQUIRE;
                        lock_d      = 1'b0;
                        lost_lock_d = 1'b1;
                        good_d      = '0;
                        bad_d       = '0;
                     end else begin
                        bad_d = bad_q + BW_W'(1);
                     end
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               lock_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= ST_IDLE;
         win_cnt_q   <= '0;
         tog_cnt_q   <= '0;
         cnt_last_q  <= '0;
         cnt_err_q   <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         cnt_valid_q <= 1'b0;
         lock_q      <= 1'b0;
         lost_lock_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         cnt_last_q  <= cnt_last_d;
         cnt_err_q   <= cnt_err_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         cnt_valid_q <= cnt_valid_d;
         lock_q      <= lock_d;
         lost_lock_q <= lost_lock_d;
      end
   end

   assign cnt_valid = cnt_valid_q;
   assign cnt_last  = cnt_last_q;
   assign cnt_err   = cnt_err_q;
   assign lock      = lock_q;
   assign lost_lock = lost_lock_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed/randomized bench for pll_lock_detect: random toggle placement per window,
// expected window results and lock behaviour from a window-level reference model.
module tb_pll_lock_detect;

   localparam int WIN         = 1024;
   localparam int EXP         = 320;
   localparam int TOL         = 1;
   localparam int LOCK_WINS   = 4;
   localparam int UNLOCK_WINS = 2;
   localparam int SLOTS       = 504;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic en_sat = 1'b0;
   logic fb_tog = 1'b0;

   logic               cnt_valid, lock, lost_lock;
   logic [15:0]        cnt_last;
   logic signed [16:0] cnt_err;
   logic               sat_valid, sat_lock, sat_lost;
   logic [7:0]         sat_last;
   logic signed [8:0]  sat_err;

   always #5 clk = ~clk;

   pll_lock_detect u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fb_tog    (fb_tog),
      .cnt_valid (cnt_valid),
      .cnt_last  (cnt_last),
      .cnt_err   (cnt_err),
      .lock      (lock),
      .lost_lock (lost_lock)
   );

   pll_lock_detect #(.CNT_W(8)) u_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_sat),
      .fb_tog    (fb_tog),
      .cnt_valid (sat_valid),
      .cnt_last  (sat_last),
      .cnt_err   (sat_err),
      .lock      (sat_lock),
      .lost_lock (sat_lost)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Window-level reference model, index 0 = default instance, 1 = 8-bit instance.
   int cap_w[2]   = '{16, 8};
   int run_len[2] = '{0, 0};
   bit lock_m[2]  = '{1'b0, 1'b0};
   bit lost_m[2]  = '{1'b0, 1'b0};

   bit pend     = 1'b0;
   bit sat_pend = 1'b0;
   int pend_n   = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear(input int i);
      run_len[i] = 0;
      lock_m[i]  = 1'b0;
      lost_m[i]  = 1'b0;
   endtask

   // A window "argues" for a change when it is good while unlocked or bad while locked.
   task automatic model_window(input int i, input int n, output int seen);
      int cap;
      bit good;
      cap  = (1 << cap_w[i]) - 1;
      seen = (n < cap) ? n : cap;
      good = (seen < cap) && (seen >= EXP - TOL) && (seen <= EXP + TOL);
      if (good != lock_m[i]) run_len[i]++;
      else run_len[i] = 0;
      if (!lock_m[i] && run_len[i] == LOCK_WINS) begin
         lock_m[i]  = 1'b1;
         run_len[i] = 0;
      end else if (lock_m[i] && run_len[i] == UNLOCK_WINS) begin
         lock_m[i]  = 1'b0;
         lost_m[i]  = 1'b1;
         run_len[i] = 0;
      end
   endtask

   task automatic check_pending();
      int seen;
      if (pend) begin
         model_window(0, pend_n, seen);
         chk("valid", cnt_valid, 1);
         chk("cnt_last", cnt_last, seen);
         chk("cnt_err", cnt_err, seen - EXP);
         chk("lock", lock, lock_m[0]);
         chk("lost_lock", lost_lock, lost_m[0]);
         $display("window toggles=%0d cnt_last=%0d cnt_err=%0d lock=%0d lost_lock=%0d",
                  pend_n, cnt_last, cnt_err, lock, lost_lock);
         if (sat_pend) begin
            model_window(1, pend_n, seen);
            chk("sat_valid", sat_valid, 1);
            chk("sat_cnt_last", sat_last, seen);
            chk("sat_cnt_err", sat_err, seen - EXP);
            chk("sat_lock", sat_lock, lock_m[1]);
            $display("sat window toggles=%0d cnt_last=%0d cnt_err=%0d lock=%0d",
                     pend_n, sat_last, sat_err, sat_lock);
         end
         pend     = 1'b0;
         sat_pend = 1'b0;
      end else begin
         chk("no_valid", cnt_valid, 0);
      end
   endtask

   // One full window with n toggles at random slots, kept clear of both window edges.
   task automatic run_window(input int n);
      bit sched[WIN];
      bit used[SLOTS];
      int k;
      int s;
      int stray;
      k = 0;
      stray = 0;
      while (k < n) begin
         s = $urandom_range(SLOTS - 1);
         if (!used[s]) begin
            used[s] = 1'b1;
            sched[8 + 2 * s] = 1'b1;
            k++;
         end
      end
      for (int c = 0; c < WIN; c++) begin
         @(negedge clk);
         if (c == 0) check_pending();
         else if (cnt_valid !== 1'b0 || sat_valid !== 1'b0) stray++;
         if (c == WIN / 2) chk("lock_hold", lock, lock_m[0]);
         if (sched[c]) fb_tog = ~fb_tog;
      end
      chk("stray_valid", stray, 0);
      pend     = 1'b1;
      sat_pend = en_sat;
      pend_n   = n;
   endtask

   task automatic run_partial(input int ncyc);
      int stray;
      stray = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (c == 0) check_pending();
         else if (cnt_valid !== 1'b0 || sat_valid !== 1'b0) stray++;
      end
      chk("partial_no_valid", stray, 0);
   endtask

   task automatic abort_now();
      @(negedge clk);
      en     = 1'b0;
      en_sat = 1'b0;
      model_clear(0);
      model_clear(1);
      pend     = 1'b0;
      sat_pend = 1'b0;
      @(negedge clk);
      chk("abort_lock", lock, 0);
      chk("abort_lost_lock", lost_lock, 0);
      chk("abort_valid", cnt_valid, 0);
   endtask

   task automatic start(input bit with_sat);
      @(negedge clk);
      en     = 1'b1;
      en_sat = with_sat;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, cnt_valid, 0);
      chk({tag, "_cnt_last"}, cnt_last, 0);
      chk({tag, "_cnt_err"}, cnt_err, 0);
      chk({tag, "_lock"}, lock, 0);
      chk({tag, "_lost_lock"}, lost_lock, 0);
      chk({tag, "_sat_last"}, sat_last, 0);
      chk({tag, "_sat_err"}, sat_err, 0);
      chk({tag, "_sat_lock"}, sat_lock, 0);
   endtask

   initial begin
      // Reset state, then idle with en low.
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      run_partial(5);

      // Nominal 320 toggles: lock rises on the 4th result.
      start(1'b0);
      repeat (5) run_window(EXP);

      // Single bad window keeps lock, two drop it; tolerance edges relock.
      run_window(300);
      run_window(EXP);
      run_window(300);
      run_window(300);
      run_window(EXP - 1);
      run_window(EXP + 1);
      run_window(EXP - 1);
      run_window(EXP + 1);
      run_window(EXP);

      // Abort mid-window, then a fresh full-length window.
      run_partial(500);
      abort_now();
      run_partial(20);
      start(1'b0);

      // Just outside tolerance never locks, then random counts.
      run_window(EXP - 2);
      run_window(EXP + 2);
      run_window(EXP - 2);
      run_window(EXP + 2);
      run_window(EXP - 2);
      repeat (4) run_window($urandom_range(EXP + 20, EXP - 20));
      repeat (5) run_window(EXP - 1 + $urandom_range(2));
      run_partial(1);
      abort_now();

      // 8-bit counter instance saturates instead of wrapping.
      start(1'b1);
      run_window(300);
      run_window(255);
      run_window(250);
      run_window(300);

      // Asynchronous reset mid-window.
      run_partial(300);
      @(negedge clk);
      rst_n  = 1'b0;
      en     = 1'b0;
      en_sat = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_clear(0);
      model_clear(1);
      pend     = 1'b0;
      sat_pend = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      run_partial(5);
      chk_all_zero("post_reset");
      start(1'b0);
      run_window(EXP);
      run_partial(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
